io_stage_varlat: RTL

//  Memory (IO) stage of the 5-stage MIPS core, successor to the fixed-latency stage.

---
 rtl/io_stage_varlat.sv | 132 +++++++++++++
 1 files changed

// File: rtl/io_stage_varlat.sv
// Memory stage between EX and WB. Loads park in WAIT until the SRAM answers, then the
// sized/signed data is extracted and retired. A flushed load drops its response in DISCARD.
module io_stage_varlat #(
   parameter int PC_WIDTH       = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      wb_allow_in,
   output logic                      io_allow_in,
   input  logic                      ex_valid,
   input  logic [PC_WIDTH-1:0]       ex_pc,
   input  logic [DATA_WIDTH-1:0]     ex_alu_result,
   input  logic [REG_ADDR_WIDTH-1:0] ex_dest,
   input  logic                      ex_reg_write,
   input  logic                      ex_is_load,
   input  logic [1:0]                ex_load_size,
   input  logic                      ex_load_signed,
   input  logic                      data_ok,
   input  logic [DATA_WIDTH-1:0]     data_rdata,
   output logic                      wb_valid,
   output logic [PC_WIDTH-1:0]       wb_pc,
   output logic [DATA_WIDTH-1:0]     wb_result,
   output logic [REG_ADDR_WIDTH-1:0] wb_dest,
   output logic                      wb_reg_write,
   output logic [REG_ADDR_WIDTH-1:0] bp_dest,
   output logic [DATA_WIDTH-1:0]     bp_value,
   output logic                      bp_value_ready
);
   localparam int OFF_W = $clog2(DATA_WIDTH/8);

   typedef enum logic [1:0] {EMPTY, HOLD, WAIT, DISCARD} state_t;
   state_t state, state_n;

   logic [PC_WIDTH-1:0]       pc_q;
   logic [DATA_WIDTH-1:0]     addr_q;
   logic [DATA_WIDTH-1:0]     result_q;
   logic [REG_ADDR_WIDTH-1:0] dest_q;
   logic                      rw_q;
   logic [1:0]                size_q;
   logic                      sgn_q;
   logic                      accept;

   assign io_allow_in = (state == EMPTY) | ((state == HOLD) & wb_allow_in);
   assign accept      = ex_valid & io_allow_in & ~flush;

   always_comb begin
      state_n = state;
      if (flush) begin
         case (state)
            WAIT, DISCARD: state_n = data_ok ? EMPTY : DISCARD;
            default:       state_n = EMPTY;
         endcase
      end else begin
         case (state)
            EMPTY:   if (accept) state_n = ex_is_load ? WAIT : HOLD;
            HOLD:    if (wb_allow_in) state_n = accept ? (ex_is_load ? WAIT : HOLD) : EMPTY;
            WAIT:    if (data_ok) state_n = HOLD;
            DISCARD: if (data_ok) state_n = EMPTY;
            default: state_n = EMPTY;
         endcase
      end
   end

   // Lane extraction from the latched address; misalignment was already trapped in EX.
   logic [OFF_W-1:0]      off, wsel;
   logic [7:0]            ld_b;
   logic [15:0]           ld_h;
   logic [31:0]           ld_w;
   logic [DATA_WIDTH-1:0] ld_ext;

   assign off  = addr_q[OFF_W-1:0];
   assign wsel = off >> 2;
   assign ld_b = data_rdata[{off, 3'b000} +: 8];
   assign ld_h = data_rdata[{off[OFF_W-1:1], 4'b0000} +: 16];
   assign ld_w = data_rdata[{wsel, 5'b00000} +: 32];

   always_comb begin
      ld_ext = '0;
      case (size_q)
         2'd0: begin
            ld_ext = DATA_WIDTH'(ld_b);
            if (sgn_q & ld_b[7]) ld_ext = ld_ext | ({DATA_WIDTH{1'b1}} << 8);
         end
         2'd1: begin
            ld_ext = DATA_WIDTH'(ld_h);
            if (sgn_q & ld_h[15]) ld_ext = ld_ext | ({DATA_WIDTH{1'b1}} << 16);
         end
         default: begin
            ld_ext = DATA_WIDTH'(ld_w);
            if (sgn_q & ld_w[31]) ld_ext = ld_ext | ({DATA_WIDTH{1'b1}} << 32);
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= EMPTY;
         pc_q     <= '0;
         addr_q   <= '0;
         result_q <= '0;
         dest_q   <= '0;
         rw_q     <= 1'b0;
         size_q   <= 2'd0;
         sgn_q    <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            pc_q     <= ex_pc;
            addr_q   <= ex_alu_result;
            result_q <= ex_alu_result;
            dest_q   <= ex_dest;
            rw_q     <= ex_reg_write;
            size_q   <= ex_load_size;
            sgn_q    <= ex_load_signed;
         end else if ((state == WAIT) & data_ok & ~flush) begin
            result_q <= ld_ext;
         end
      end
   end

   assign wb_valid       = (state == HOLD);
   assign wb_pc          = pc_q;
   assign wb_result      = result_q;
   assign wb_dest        = dest_q;
   assign wb_reg_write   = rw_q;
   assign bp_dest        = (((state == HOLD) | (state == WAIT)) & rw_q) ? dest_q : '0;
   assign bp_value       = result_q;
   assign bp_value_ready = (state == HOLD);
endmodule
